aurora_lane_serializer: RTL and testbench
=========================================

# aurora_lane_serializer

Transmit-side lane serializer feeding the Aurora lane outputs. It accepts 8-bit words over a valid/ready handshake and stripes each word over one lane (8 beats) or four lanes (2 beats). All logic runs on the fast clock, so the word rate equals the divided clock rate: clk_in/8 in single-lane mode and clk_in/2 in quad-lane mode. A 2-entry input FIFO absorbs producer jitter.

## Interface
- FIFO_DEPTH, 2, input FIFO entries; a power of two, at least 2.
- clk_in  input  1  fast bit clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- single_lane  input  1  1 = one lane, 8 beats per word; 0 = four lanes, 2 beats per word. Sampled per word.
- tx_data  input  8  word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  a registered signal; high when the FIFO can accept a word.
- lane_out  output  4  lane bits, registered.
- lane_valid  output  1  lane_out carries a data beat, registered.
- word_start  output  1  pulses high on the first beat of each word, registered.

## Operation
- **Reset.** While rst_n is low, all outputs are 0: tx_ready=0, lane_out=0, lane_valid=0, word_start=0. The FIFO is emptied and the shifter goes idle. tx_ready rises at the first clk_in edge after rst_n is released.
- **Reset mid-word.** Assertion takes effect immediately (asynchronously). The partial word and all FIFO contents are discarded.
- **Push.** A word is pushed when tx_valid && tx_ready at a rising edge.
- **tx_ready.** tx_ready is registered as !(FIFO full after this edge's push and pop).
- **FIFO count rules.**
  - Push and pop on the same edge leaves the count unchanged.
  - A push with tx_ready low is impossible by construction.
  - tx_data and tx_valid are ignored while tx_ready is 0.
- **Shifter states.** The shifter has two states:
  - IDLE: lane_valid=0 and lane_out=0.
  - SHIFT: carries a beat counter, 0..7 in single-lane mode and 0..1 in quad-lane mode.
- **Load.** A load happens at any edge where the FIFO is non-empty and the shifter is in IDLE or on its last beat. On load:
  - the FIFO is popped;
  - single_lane is latched into mode_q for the whole word;
  - the beat counter is set to 0;
  - word_start=1 is driven for that beat.
- **Last beat, FIFO empty.** The shifter returns to IDLE at the next edge.
- **Single-lane beats.** Beat k drives lane_out[0] = word[7-k] (MSB first); lane_out[3:1] = 0.
- **Quad-lane beats.** Beat 0 drives lane_out = word[7:4]; beat 1 drives lane_out = word[3:0].
- **Mode changes.**
  - A change of single_lane mid-word has no effect on the current word.
  - It applies from the next load onward.
- **Underrun.** If the FIFO is empty at the last beat, lane_valid drops for at least one cycle. No filler pattern is sent.

## Timing
- **Latency.** A word accepted at edge E, with the shifter idle and the FIFO empty, is loaded at edge E+1. Its first beat is on the outputs after E+1.
- **Back-to-back words.**
  - While the FIFO is non-empty, consecutive words have no gap: the next word's beat 0 directly follows the previous word's last beat.
  - lane_valid stays high across the boundary.
  - word_start is high for exactly one cycle per word.
- **Throughput.** Sustained rate is 1 word per 8 cycles (single-lane) or 1 word per 2 cycles (quad-lane).
- **Stall capacity.** With tx_valid held high and no pop, at most FIFO_DEPTH words are buffered plus one word in the shifter.
- **Output transitions.** lane_out, lane_valid and word_start change only on clk_in rising edges or on async reset.

## Test plan
- **Single-lane word.** single_lane=1, push 0xA5 at edge E -> starting after E+1, lane_out[0] = 1,0,1,0,0,1,0,1 over 8 cycles; lane_valid high for 8 cycles; word_start high only in the first; then IDLE with lane_out=0.
- **Quad-lane streaming.** single_lane=0, push 0x12, 0x34 and 0x3C on consecutive edges -> lane_out = 1,2,3,4,3,C with lane_valid continuously high for 6 cycles and word_start on beats 1, 3 and 5.
- **Backpressure.** single_lane=1, tx_valid held high with words 0x01..0x05 -> exactly 3 words are accepted before tx_ready falls. After that, tx_ready re-asserts once per 8 cycles. The output order is 0x01, 0x02, 0x03, ... with no gaps.
- **Mode change mid-word.** single_lane=1, push 0xF0 then 0x0F; toggle single_lane to 0 during the 3rd beat of 0xF0 -> 0xF0 completes 8 serial beats; 0x0F is then sent as lane_out = 0, F.
- **Async reset mid-word.** Pull rst_n low between edges while in SHIFT with 2 words queued -> all outputs are 0 immediately, without waiting for an edge. After release, tx_ready=1 at the first edge, and no old data ever appears.
- **Underrun and restart.** single_lane=0, push one word, wait 5 cycles, push 0xAA -> lane_valid has a gap, then lane_out = A, A with word_start on the first beat.

Source files
------------

// File: rtl/aurora_lane_serializer.sv
// Transmit lane serializer: buffers 8-bit words in a small FIFO and stripes each
// word MSB-first over one lane (8 beats) or four lanes (2 beats).
module aurora_lane_serializer #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       single_lane,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [3:0] lane_out,
  output logic       lane_valid,
  output logic       word_start
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          mode_q;
  logic [2:0]    beat_q;
  logic [7:0]    word_q;
  logic          push;
  logic          pop;
  logic          last_beat;
  logic [7:0]    head;

  assign head      = mem[rd_ptr];
  assign last_beat = (state == SHIFT) && (beat_q == (mode_q ? 3'd7 : 3'd1));
  assign push      = tx_valid && tx_ready;
  // A load pops the FIFO whenever the shifter is free at this edge.
  assign pop       = (count != '0) && ((state == IDLE) || last_beat);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // Lane pattern for beat k of word w in the given mode.
  function automatic logic [3:0] beat_bits(input logic [7:0] w, input logic sl,
                                           input logic [2:0] k);
    logic [3:0] b;
    b = 4'd0;
    if (sl) begin
      b[0] = w[3'd7 - k];
    end else begin
      b = k[0] ? w[3:0] : w[7:4];
    end
    return b;
  endfunction

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      tx_ready <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  // Shifter FSM with registered lane outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      beat_q     <= 3'd0;
      word_q     <= 8'd0;
      lane_out   <= 4'd0;
      lane_valid <= 1'b0;
      word_start <= 1'b0;
    end else if (pop) begin
      state      <= SHIFT;
      mode_q     <= single_lane;
      beat_q     <= 3'd0;
      word_q     <= head;
      lane_out   <= beat_bits(head, single_lane, 3'd0);
      lane_valid <= 1'b1;
      word_start <= 1'b1;
    end else if ((state == SHIFT) && !last_beat) begin
      beat_q     <= beat_q + 3'd1;
      lane_out   <= beat_bits(word_q, mode_q, beat_q + 3'd1);
      lane_valid <= 1'b1;
      word_start <= 1'b0;
    end else begin
      state      <= IDLE;
      beat_q     <= 3'd0;
      lane_out   <= 4'd0;
      lane_valid <= 1'b0;
      word_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aurora_lane_serializer.sv
// Bench for aurora_lane_serializer: word/beat-list model checked every cycle,
// plus literal output traces for the directed scenarios.
module tb_aurora_lane_serializer;

  localparam int unsigned DEPTH = 2;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       single_lane;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] lane_out;
  logic       lane_valid;
  logic       word_start;

  aurora_lane_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .single_lane(single_lane),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .lane_out   (lane_out),
    .lane_valid (lane_valid),
    .word_start (word_start)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [7:0] act,
                                input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: FIFO of words plus a list of pending beats ({start, lane}) of the current word.
  logic [7:0] mq [$];
  logic [4:0] pend [$];
  logic       m_ready = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_start = 1'b0;
  logic [3:0] m_lane  = 4'd0;
  int         m_pushes = 0;
  logic       m_push;
  logic [7:0] m_w;
  logic [4:0] m_b;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_start = 1'b0;
      m_lane  = 4'd0;
    end else begin
      m_push = tx_valid && m_ready;
      if (pend.size() == 0 && mq.size() != 0) begin
        m_w = mq.pop_front();
        if (single_lane) begin
          for (int k = 0; k < 8; k++) pend.push_back({k == 0, 3'b000, m_w[7-k]});
        end else begin
          pend.push_back({1'b1, m_w[7:4]});
          pend.push_back({1'b0, m_w[3:0]});
        end
      end
      if (pend.size() != 0) begin
        m_b     = pend.pop_front();
        m_valid = 1'b1;
        m_start = m_b[4];
        m_lane  = m_b[3:0];
      end else begin
        m_valid = 1'b0;
        m_start = 1'b0;
        m_lane  = 4'd0;
      end
      if (m_push) begin
        mq.push_back(tx_data);
        m_pushes++;
      end
      m_ready = (mq.size() != DEPTH);
    end
  end

  always @(negedge clk_in) begin
    check("tx_ready", 8'(tx_ready), 8'(m_ready));
    check("lane_out", 8'(lane_out), 8'(m_lane));
    check("lane_valid", 8'(lane_valid), 8'(m_valid));
    check("word_start", 8'(word_start), 8'(m_start));
  end

  logic [5:0] trace [$];
  logic [5:0] expq  [$];

  task automatic step();
    @(negedge clk_in);
    trace.push_back({lane_valid, word_start, lane_out});
  endtask

  task automatic check_trace(input string name);
    check({name, "_len"}, 8'(trace.size()), 8'(expq.size()));
    for (int i = 0; i < expq.size() && i < trace.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), 8'(trace[i]), 8'(expq[i]));
    end
  endtask

  int base;
  int nv;
  int ns;

  initial begin
    rst_n = 1'b0; single_lane = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_tx_ready", 8'(tx_ready), 8'h0);
    check("rst_lane_out", 8'(lane_out), 8'h0);
    check("rst_lane_valid", 8'(lane_valid), 8'h0);
    check("rst_word_start", 8'(word_start), 8'h0);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("ready_after_release", 8'(tx_ready), 8'h1);

    // Single-lane 0xA5
    trace.delete(); step();
    single_lane = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    step(); tx_valid = 1'b0;
    repeat (9) step();
    expq = '{6'h00, 6'h00, 6'h31, 6'h20, 6'h21, 6'h20, 6'h20, 6'h21, 6'h20, 6'h21, 6'h00};
    check_trace("single_a5");
    repeat (4) step();

    // Quad-lane streaming 0x12, 0x34, 0x3C
    trace.delete(); step();
    single_lane = 1'b0; tx_valid = 1'b1; tx_data = 8'h12;
    step(); tx_data = 8'h34;
    step(); tx_data = 8'h3C;
    step(); tx_valid = 1'b0;
    repeat (5) step();
    expq = '{6'h00, 6'h00, 6'h31, 6'h22, 6'h33, 6'h24, 6'h33, 6'h2C, 6'h00};
    check_trace("quad_stream");
    repeat (4) step();

    // Backpressure with words 0x01..0x05
    single_lane = 1'b1;
    base = m_pushes;
    trace.delete();
    for (int i = 0; i < 120; i++) begin
      step();
      if (i == 1 || i == 2) check("bp_ready_open", 8'(tx_ready), 8'h1);
      if (i == 3) check("bp_ready_full", 8'(tx_ready), 8'h0);
      if (m_pushes - base >= 5) begin
        tx_valid = 1'b0;
        break;
      end
      tx_valid = 1'b1;
      tx_data  = 8'(1 + m_pushes - base);
    end
    check("bp_accepted", 8'(m_pushes - base), 8'd5);
    repeat (40) step();
    nv = 0; ns = 0;
    foreach (trace[i]) begin
      if (trace[i][5]) nv++;
      if (trace[i][4]) ns++;
    end
    check("bp_valid_beats", 8'(nv), 8'd40);
    check("bp_word_starts", 8'(ns), 8'd5);
    repeat (4) step();

    // Mode change during 3rd beat of 0xF0
    trace.delete(); step();
    single_lane = 1'b1; tx_valid = 1'b1; tx_data = 8'hF0;
    step(); tx_data = 8'h0F;
    step(); tx_valid = 1'b0;
    step();
    step(); single_lane = 1'b0;
    repeat (8) step();
    expq = '{6'h00, 6'h00, 6'h31, 6'h21, 6'h21, 6'h21, 6'h20, 6'h20, 6'h20, 6'h20,
             6'h30, 6'h2F, 6'h00};
    check_trace("mode_change");
    repeat (4) step();

    // Underrun and restart
    trace.delete(); step();
    single_lane = 1'b0; tx_valid = 1'b1; tx_data = 8'h5B;
    step(); tx_valid = 1'b0;
    repeat (4) step();
    step(); tx_valid = 1'b1; tx_data = 8'hAA;
    step(); tx_valid = 1'b0;
    repeat (3) step();
    expq = '{6'h00, 6'h00, 6'h35, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3A, 6'h2A, 6'h00};
    check_trace("underrun");
    repeat (4) step();

    // Async reset mid-word with two words queued
    single_lane = 1'b1;
    step(); tx_valid = 1'b1; tx_data = 8'h11;
    step(); tx_data = 8'h22;
    step(); tx_data = 8'h33;
    step(); tx_valid = 1'b0;
    step();
    check("pre_rst_valid", 8'(lane_valid), 8'h1);
    check("pre_rst_ready", 8'(tx_ready), 8'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx_ready", 8'(tx_ready), 8'h0);
    check("async_lane_out", 8'(lane_out), 8'h0);
    check("async_lane_valid", 8'(lane_valid), 8'h0);
    check("async_word_start", 8'(word_start), 8'h0);
    @(negedge clk_in);
    rst_n = 1'b1;
    trace.delete();
    step();
    check("rst_ready_first_edge", 8'(tx_ready), 8'h1);
    repeat (11) step();
    nv = 0;
    foreach (trace[i]) if (trace[i][5] || trace[i][3:0] != 4'd0) nv++;
    check("no_stale_data", 8'(nv), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
